mdio_smi_master: RTL and testbench

MDIO_SMI_MASTER -- requirements
Module: mdio_smi_master

---
 rtl/mdio_pkg.sv | 32 +++
 rtl/mdc_tick_gen.sv | 32 +++
 rtl/mdio_smi_master.sv | 133 +++++++++++++
 tb/tb_mdio_smi_master.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO/SMI framing constants: state codes, opcodes and field lengths.
package mdio_pkg;

    localparam int PREAMBLE_LEN = 32;
    localparam int DATA_LEN     = 16;

    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    // Codes are consecutive so the frame advances with state + 1.
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_PREAMBLE = 4'd1;
    localparam logic [3:0] ST_START    = 4'd2;
    localparam logic [3:0] ST_OP       = 4'd3;
    localparam logic [3:0] ST_PHYAD    = 4'd4;
    localparam logic [3:0] ST_REGAD    = 4'd5;
    localparam logic [3:0] ST_TA       = 4'd6;
    localparam logic [3:0] ST_DATA     = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    // Index of the last bit of each frame field.
    function automatic logic [4:0] field_last(input logic [3:0] s);
        case (s)
            ST_PREAMBLE:          field_last = 5'(PREAMBLE_LEN - 1);
            ST_PHYAD, ST_REGAD:   field_last = 5'd4;
            ST_DATA:              field_last = 5'(DATA_LEN - 1);
            default:              field_last = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/mdc_tick_gen.sv
// Free-running MDC divider; rise/fall flag the clk cycle in which mdc is about to toggle.
module mdc_tick_gen #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int CW = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == CW'(DIV - 1));
    assign rise = tick & ~mdc;
    assign fall = tick & mdc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick)
                mdc <= ~mdc;
        end
    end

endmodule

// File: rtl/mdio_smi_master.sv
// Clause-22 MDIO master: one read or write frame per request, driven on MDC falls, sampled on rises.
module mdio_smi_master
    import mdio_pkg::*;
#(
    parameter int REF_CLK = 100,
    parameter int MDC_CLK = 500
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mdc,
    inout  wire         mdio,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic        write_req,
    input  logic [15:0] write_data,
    input  logic        read_req,
    output logic [15:0] read_data,
    output logic        data_valid,
    output logic        done,
    output logic [7:0]  debug
);

    localparam int DIV = REF_CLK * 1000 / (2 * MDC_CLK);

    logic        rise, fall;
    logic [3:0]  state, adv_state;
    logic [4:0]  bit_cnt, adv_cnt;
    logic        armed, is_rd, ta_err;
    logic [31:0] tx_sr;
    logic [14:0] rx_sr;
    logic        mdio_oe, mdio_o, mdio_in;
    logic        nxt_bit, nxt_oe;

    mdc_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .mdc  (mdc),
        .rise (rise),
        .fall (fall)
    );

    assign mdio    = mdio_oe ? mdio_o : 1'bz;
    assign mdio_in = mdio;
    assign debug   = {state, ta_err, mdio_oe, mdio_in, mdc};

    // (state, bit_cnt) names the bit currently on the line; compute the one to drive next.
    always_comb begin
        adv_state = state;
        adv_cnt   = bit_cnt + 5'd1;
        if (bit_cnt == field_last(state)) begin
            adv_state = state + 4'd1;
            adv_cnt   = '0;
        end
        nxt_oe  = 1'b1;
        nxt_bit = 1'b1;
        if (adv_state == ST_TA || adv_state == ST_DATA)
            nxt_oe = ~is_rd;
        if (adv_state != ST_PREAMBLE)
            nxt_bit = (state == ST_PREAMBLE) ? tx_sr[31] : tx_sr[30];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            armed      <= 1'b0;
            is_rd      <= 1'b0;
            ta_err     <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            mdio_oe    <= 1'b0;
            mdio_o     <= 1'b0;
            read_data  <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (write_req || read_req) begin
                        state   <= ST_PREAMBLE;
                        bit_cnt <= '0;
                        armed   <= 1'b0;
                        is_rd   <= ~write_req;
                        ta_err  <= 1'b0;
                        tx_sr   <= {START, write_req ? OP_WR : OP_RD, phy_addr, reg_addr,
                                    2'b10, write_data};
                    end
                end
                ST_DONE: begin
                    if (fall) begin
                        mdio_oe <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    if (fall) begin
                        if (!armed) begin
                            // First fall after accept puts preamble bit 0 on the line.
                            armed   <= 1'b1;
                            mdio_oe <= 1'b1;
                            mdio_o  <= 1'b1;
                        end else begin
                            state   <= adv_state;
                            bit_cnt <= adv_cnt;
                            mdio_oe <= nxt_oe;
                            mdio_o  <= nxt_bit;
                            if (state != ST_PREAMBLE)
                                tx_sr <= {tx_sr[30:0], 1'b0};
                        end
                    end
                    if (rise && armed) begin
                        if (state == ST_TA && bit_cnt == 5'd1 && is_rd)
                            ta_err <= mdio_in;
                        if (state == ST_DATA) begin
                            rx_sr <= {rx_sr[13:0], mdio_in};
                            if (bit_cnt == 5'(DATA_LEN - 1)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                if (is_rd) begin
                                    read_data  <= {rx_sr, mdio_in};
                                    data_valid <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_smi_master.sv
// Directed bench for mdio_smi_master: line capture on MDC rises plus a simple PHY read responder.
module tb_mdio_smi_master;

    localparam int REF = 10;
    localparam int MDCK = 1000;
    localparam int DIV = REF * 1000 / (2 * MDCK);
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    localparam logic [63:0] EXP_W1 = {ONES, 2'b01, 2'b01, 5'd1,   5'h16, 2'b10, 16'h0012};
    localparam logic [63:0] EXP_R1 = {ONES, 2'b01, 2'b10, 5'd1,   5'h14, 2'b10, 16'hABCD};
    localparam logic [63:0] EXP_R2 = {ONES, 2'b01, 2'b10, 5'd3,   5'd2,  2'b11, 16'hFFFF};
    localparam logic [63:0] EXP_B  = {ONES, 2'b01, 2'b01, 5'h1F,  5'h00, 2'b10, 16'hA5C3};
    localparam logic [63:0] EXP_M  = {ONES, 2'b01, 2'b01, 5'd2,   5'd3,  2'b10, 16'h1234};
    localparam logic [63:0] EXP_P  = {ONES, 2'b01, 2'b01, 5'd5,   5'd6,  2'b10, 16'h8001};

    logic        clk, rst;
    logic        mdc;
    wire         mdio;
    logic [4:0]  phy_addr, reg_addr;
    logic        write_req, read_req;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        data_valid, done;
    logic [7:0]  debug;

    mdio_smi_master #(.REF_CLK(REF), .MDC_CLK(MDCK)) dut (
        .clk        (clk),
        .rst        (rst),
        .mdc        (mdc),
        .mdio       (mdio),
        .phy_addr   (phy_addr),
        .reg_addr   (reg_addr),
        .write_req  (write_req),
        .write_data (write_data),
        .read_req   (read_req),
        .read_data  (read_data),
        .data_valid (data_valid),
        .done       (done),
        .debug      (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PHY side: fidx is the frame bit index, restarted at the first MDC fall after each accept.
    pullup (mdio);
    logic        phy_en = 1'b0;
    logic [15:0] phy_data = 16'h0000;
    int          req_seq = 0, seen_seq = 0, fidx = 100;
    logic [63:0] cap = '0;
    logic        phy_oe, phy_bit;

    always @(negedge mdc) begin
        seen_seq <= req_seq;
        fidx     <= (seen_seq != req_seq) ? 0 : fidx + 1;
    end

    assign phy_oe  = phy_en && fidx >= 47 && fidx <= 63;
    assign phy_bit = (fidx >= 48 && fidx <= 63) ? phy_data[4'(63 - fidx)] : 1'b0;
    assign mdio    = phy_oe ? phy_bit : 1'bz;

    always @(posedge mdc)
        if (fidx >= 0 && fidx <= 63)
            cap[6'(63 - fidx)] <= mdio;

    int done_cnt = 0, dv_cnt = 0, dv_alone = 0;
    always @(negedge clk) begin
        if (done)               done_cnt <= done_cnt + 1;
        if (data_valid)         dv_cnt   <= dv_cnt + 1;
        if (data_valid && !done) dv_alone <= dv_alone + 1;
    end

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd);
        @(negedge clk);
        phy_addr = pa; reg_addr = ra; write_data = wd;
        write_req = wr; read_req = rd;
        @(negedge clk);
        write_req = 1'b0; read_req = 1'b0;
        req_seq++;
    endtask

    // Latencies are measured from the first MDC fall after accept; -1 means never seen.
    task automatic run_frame(input logic wr, input logic rd, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd, input int inj,
                             output int lat_done, output int lat_idle);
        int tf, td, ti;
        logic mq;
        issue(wr, rd, pa, ra, wd);
        tf = -1; td = -1; ti = -1;
        mq = mdc;
        for (int i = 0; i < 200 * DIV && ti < 0; i++) begin
            read_req = (i == inj);
            @(negedge clk);
            if (tf < 0 && mq && !mdc) tf = i;
            if (done && td < 0) td = i;
            if (td >= 0 && ti < 0 && debug[7:4] == 4'd0) ti = i;
            mq = mdc;
        end
        read_req = 1'b0;
        lat_done = (td < 0 || tf < 0) ? -1 : td - tf;
        lat_idle = (ti < 0 || tf < 0) ? -1 : ti - tf;
    endtask

    int ld, li, dc0, dv0;
    logic hit;

    initial begin
        rst = 1'b1;
        phy_addr = '0; reg_addr = '0; write_data = '0;
        write_req = 1'b0; read_req = 1'b0;
        #23;
        chk("rst_state", {debug[7:4], debug[2], mdc, data_valid, done}, 64'd0);
        chk("rst_rdata", read_data, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // write phy 1 reg 0x16 data 0x0012
        dc0 = done_cnt; dv0 = dv_cnt;
        run_frame(1'b1, 1'b0, 5'd1, 5'h16, 16'h0012, -1, ld, li);
        chk("w1_frame", cap, EXP_W1);
        chk("w1_done_lat", 64'(ld), 64'(127 * DIV));
        chk("w1_frame_len", 64'(li), 64'(128 * DIV));
        chk("w1_done_cnt", 64'(done_cnt - dc0), 64'd1);
        chk("w1_no_dv", 64'(dv_cnt - dv0), 64'd0);

        // read phy 1 reg 0x14 from a PHY returning 0xABCD
        phy_en = 1'b1; phy_data = 16'hABCD;
        dc0 = done_cnt; dv0 = dv_cnt;
        run_frame(1'b0, 1'b1, 5'd1, 5'h14, 16'h0000, -1, ld, li);
        phy_en = 1'b0;
        chk("r1_frame", cap, EXP_R1);
        chk("r1_rdata", read_data, 64'hABCD);
        chk("r1_dv_cnt", 64'(dv_cnt - dv0), 64'd1);
        chk("r1_dv_with_done", 64'(dv_alone), 64'd0);
        chk("r1_ta_err", debug[3], 64'd0);
        chk("r1_done_lat", 64'(ld), 64'(127 * DIV));

        // read with no PHY: pull-up gives all ones and a TA error
        dv0 = dv_cnt;
        run_frame(1'b0, 1'b1, 5'd3, 5'd2, 16'h0000, -1, ld, li);
        chk("r2_frame", cap, EXP_R2);
        chk("r2_rdata", read_data, 64'hFFFF);
        chk("r2_ta_err", debug[3], 64'd1);
        chk("r2_dv_cnt", 64'(dv_cnt - dv0), 64'd1);

        // write and read in the same cycle: write wins
        dv0 = dv_cnt;
        run_frame(1'b1, 1'b1, 5'h1F, 5'h00, 16'hA5C3, -1, ld, li);
        chk("both_op", {cap[29], cap[28]}, 64'b01);
        chk("both_frame", cap, EXP_B);
        chk("both_ta_clr", debug[3], 64'd0);
        chk("both_no_dv", 64'(dv_cnt - dv0), 64'd0);
        chk("both_rdata_hold", read_data, 64'hFFFF);

        // read_req mid-frame during a write is dropped
        dc0 = done_cnt; dv0 = dv_cnt;
        run_frame(1'b1, 1'b0, 5'd2, 5'd3, 16'h1234, 60 * DIV, ld, li);
        repeat (20 * DIV) @(negedge clk);
        chk("mid_frame", cap, EXP_M);
        chk("mid_done_cnt", 64'(done_cnt - dc0), 64'd1);
        chk("mid_no_dv", 64'(dv_cnt - dv0), 64'd0);
        chk("mid_stays_idle", debug[7:4], 64'd0);

        // reset during DATA
        dc0 = done_cnt;
        issue(1'b1, 1'b0, 5'd5, 5'd6, 16'hFFFF);
        hit = 1'b0;
        for (int i = 0; i < 200 * DIV && !hit; i++) begin
            @(negedge clk);
            hit = (debug[7:4] == 4'd7);
        end
        chk("rst_reach_data", hit, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_mdc", mdc, 64'd0);
        chk("rst_async_oe", debug[2], 64'd0);
        chk("rst_async_state", debug[7:4], 64'd0);
        chk("rst_async_rdata", read_data, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - dc0), 64'd0);
        run_frame(1'b1, 1'b0, 5'd5, 5'd6, 16'h8001, -1, ld, li);
        chk("post_rst_frame", cap, EXP_P);
        chk("post_rst_len", 64'(li), 64'(128 * DIV));
        chk("post_rst_done", 64'(done_cnt - dc0), 64'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
